// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment bit positions and hex glyph table for the 7-segment scan driver
// Purpose: shared constants and the nibble-to-glyph lookup.
// Ports: none (package).
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Logical (active-high) glyphs, entry 0 in the low byte; DP bit is always 0 here.
  localparam logic [15:0][7:0] GLYPH_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [7:0] glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display data and pin bundle for the 7-segment scan driver
// Purpose: groups the load-side inputs and the display pins.
// Ports (master = core side, slave = driver side):
//   value/dp/blank_lz/load  core -> driver
//   an/seg_out/frame_done   driver -> pins/core
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 4
);

  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp;
  logic                  blank_lz;
  logic                  load;
  logic [N_DIGITS-1:0]   an;
  logic [7:0]            seg_out;
  logic                  frame_done;

  modport master (
    output value, dp, blank_lz, load,
    input  an, seg_out, frame_done
  );

  modport slave (
    input  value, dp, blank_lz, load,
    output an, seg_out, frame_done
  );

endinterface

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational nibble/dp/blank to 8-bit segment pattern
// Purpose: single shared decoder placed after the digit mux.
// Ports:
//   i_nibble  hex digit to show
//   i_dp      decimal point
//   i_blank   force segments A..G off (DP still honoured)
//   o_seg     bit0..6 = A..G, bit7 = DP, logical polarity
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  logic [7:0] w_raw;

  assign w_raw                = glyph(i_nibble);
  assign o_seg[SEG_G:SEG_A]   = i_blank ? 7'b0 : w_raw[SEG_G:SEG_A];
  assign o_seg[SEG_DP]        = i_dp;

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment driver with frame-synchronous updates
// Purpose: scans N_DIGITS digits, CLK_DIV cycles per slot, first BLANK_CYC cycles dark.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   slave side of seg7_scan_driver_if (value/dp/blank_lz/load in, an/seg_out/frame_done out)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] DIG0 = N_DIGITS'(1);

  logic [PRE_W-1:0]      r_pre;
  logic [DIG_W-1:0]      r_dig;
  logic [4*N_DIGITS-1:0] r_stage_value;
  logic [N_DIGITS-1:0]   r_stage_dp;
  logic                  r_stage_blz;
  logic                  r_pending;
  logic [4*N_DIGITS-1:0] r_shadow_value;
  logic [N_DIGITS-1:0]   r_shadow_dp;
  logic                  r_shadow_blz;
  logic [N_DIGITS-1:0]   r_an;
  logic [7:0]            r_seg;
  logic                  r_frame_done;

  logic                  w_pre_last;
  logic                  w_dig_last;
  logic                  w_boundary;
  logic                  w_active;
  logic [N_DIGITS-1:0]   w_zero_above;
  logic                  w_blank;
  logic [3:0]            w_nibble;
  logic [7:0]            w_glyph;
  logic [N_DIGITS-1:0]   w_an;
  logic [7:0]            w_seg;

  assign w_pre_last = (r_pre == PRE_W'(CLK_DIV - 1));
  assign w_dig_last = (r_dig == DIG_W'(N_DIGITS - 1));
  assign w_boundary = w_pre_last && w_dig_last;
  assign w_active   = !(r_pre < PRE_W'(BLANK_CYC));

  // Digit i is a leading zero when it and every digit to its left are zero.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
    assign w_zero_above[gi] = (r_shadow_value[4*N_DIGITS-1:4*gi] == '0);
  end

  assign w_nibble = r_shadow_value[{r_dig, 2'b00} +: 4];
  assign w_blank  = r_shadow_blz && (r_dig != '0) && w_zero_above[r_dig];

  seg7_glyph u_glyph (
    .i_nibble (w_nibble),
    .i_dp     (r_shadow_dp[r_dig]),
    .i_blank  (w_blank),
    .o_seg    (w_glyph)
  );

  assign w_an  = w_active ? (DIG0 << r_dig) : '0;
  assign w_seg = w_active ? w_glyph : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre          <= '0;
      r_dig          <= '0;
      r_stage_value  <= '0;
      r_stage_dp     <= '0;
      r_stage_blz    <= 1'b0;
      r_pending      <= 1'b0;
      r_shadow_value <= '0;
      r_shadow_dp    <= '0;
      r_shadow_blz   <= 1'b0;
      r_an           <= {N_DIGITS{POL}};
      r_seg          <= {8{POL}};
      r_frame_done   <= 1'b0;
    end else begin
      r_pre <= w_pre_last ? '0 : r_pre + 1'b1;
      if (w_pre_last) begin
        r_dig <= w_dig_last ? '0 : r_dig + 1'b1;
      end

      if (bus.load) begin
        r_stage_value <= bus.value;
        r_stage_dp    <= bus.dp;
        r_stage_blz   <= bus.blank_lz;
      end

      // A load on the boundary edge bypasses staging so it is not a frame late.
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (bus.load) begin
          r_shadow_value <= bus.value;
          r_shadow_dp    <= bus.dp;
          r_shadow_blz   <= bus.blank_lz;
        end else if (r_pending) begin
          r_shadow_value <= r_stage_value;
          r_shadow_dp    <= r_stage_dp;
          r_shadow_blz   <= r_stage_blz;
        end
      end else if (bus.load) begin
        r_pending <= 1'b1;
      end

      r_an         <= w_an ^ {N_DIGITS{POL}};
      r_seg        <= w_seg ^ {8{POL}};
      r_frame_done <= w_boundary;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg_out    = r_seg;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
// Purpose: runs an active-high and an active-low instance side by side on identical stimulus.
// Ports: none (top-level bench).
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(4)) bus0 ();
  seg7_scan_driver_if #(.N_DIGITS(4)) bus1 ();

  seg7_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seg7_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic b);
    bus0.load = ld; bus0.value = v; bus0.dp = d; bus0.blank_lz = b;
    bus1.load = ld; bus1.value = v; bus1.dp = d; bus1.blank_lz = b;
  endtask

  task automatic check_pins(input string tag, input logic [3:0] an, input logic [7:0] seg,
                            input logic fd);
    check({tag, " an"},    {28'h0, bus0.an},        {28'h0, an});
    check({tag, " seg"},   {24'h0, bus0.seg_out},   {24'h0, seg});
    check({tag, " fd"},    {31'h0, bus0.frame_done}, {31'h0, fd});
    check({tag, " an_n"},  {28'h0, bus1.an},        {28'h0, ~an});
    check({tag, " seg_n"}, {24'h0, bus1.seg_out},   {24'h0, ~seg});
    check({tag, " fd_n"},  {31'h0, bus1.frame_done}, {31'h0, fd});
  endtask

  // Runs slots 0..stop-1 of a frame (must start aligned to slot 0), optionally
  // pulsing load on slot la and slot lb; segs holds expected digit glyphs, digit i in byte i.
  task automatic frame(input string tag, input logic [31:0] segs, input int stop,
                       input int la, input logic [15:0] va, input logic [3:0] da, input logic ba,
                       input int lb, input logic [15:0] vb, input logic [3:0] db, input logic bb);
    for (int i = 0; i < stop; i++) begin
      int          pre;
      int          dig;
      logic [3:0]  e_an;
      logic [7:0]  e_seg;
      if (i == la)      drive(1'b1, va, da, ba);
      else if (i == lb) drive(1'b1, vb, db, bb);
      else              drive(1'b0, 16'h0, 4'h0, 1'b0);
      step();
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      pre   = i % 4;
      dig   = i / 4;
      e_an  = (pre == 0) ? 4'b0000 : (4'b0001 << dig);
      e_seg = (pre == 0) ? 8'h00 : segs[8*dig +: 8];
      check_pins($sformatf("%s s%0d", tag, i), e_an, e_seg, (i == 15));
    end
  endtask

  initial begin
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    rst = 1'b1;
    step();
    step();
    check_pins("reset", 4'b0000, 8'h00, 1'b0);
    rst = 1'b0;

    frame("idle", 32'h3F3F3F3F, 16, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);
    frame("old", 32'h3F3F3F3F, 16, 6, 16'h12AF, 4'b0100, 1'b0, -1, 16'h0, 4'h0, 1'b0);
    frame("12AF", 32'h06DB7771, 16, 3, 16'h0050, 4'b0000, 1'b1, -1, 16'h0, 4'h0, 1'b0);
    frame("0050", 32'h00006D3F, 16, 9, 16'h0000, 4'b0000, 1'b1, -1, 16'h0, 4'h0, 1'b0);
    frame("0000", 32'h0000003F, 16, 2, 16'h0000, 4'b1000, 1'b1, -1, 16'h0, 4'h0, 1'b0);
    frame("dp3", 32'h8000003F, 16, 4, 16'h1111, 4'b0000, 1'b0, 10, 16'h2222, 4'b0000, 1'b0);
    frame("2222", 32'h5B5B5B5B, 16, 5, 16'h7777, 4'b0000, 1'b0, 15, 16'h3456, 4'b0001, 1'b0);
    frame("3456", 32'h4F666DFD, 16, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);
    frame("keep", 32'h4F666DFD, 9, 5, 16'hAAAA, 4'b1111, 1'b0, -1, 16'h0, 4'h0, 1'b0);

    rst = 1'b1;
    step();
    check_pins("midrst", 4'b0000, 8'h00, 1'b0);
    rst = 1'b0;

    frame("post", 32'h3F3F3F3F, 16, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);
    frame("post2", 32'h3F3F3F3F, 16, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a row of N common-anode/common-cathode 7-segment digits sharing one segment bus. It takes a packed hex value, per-digit decimal points and a leading-zero-blank flag. It scans the digits at a programmable rate, with an inter-digit blanking gap against ghosting and tear-free frame-synchronous updates. It sits between the core logic and the board's display pins, replacing per-digit combinational decoders.

## Interface
- N_DIGITS, 4: number of digits scanned; ≥1.
- CLK_DIV, 50000: clock cycles per digit slot; ≥2.
- BLANK_CYC, 1: cycles at the start of each slot with all anodes off; 0 ≤ BLANK_CYC < CLK_DIV.
- ACTIVE_LOW, 0: 1 inverts both `an` and `seg_out` at the pins.

Ports:
- clk  in  1  system clock; one clock domain, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*N_DIGITS  packed nibbles; nibble i = digit i; digit 0 is rightmost.
- dp  in  N_DIGITS  decimal point per digit.
- blank_lz  in  1  blank leading zeros.
- load  in  1  capture value/dp/blank_lz this cycle.
- an  out  N_DIGITS  one-hot digit enable.
- seg_out  out  8  bit0..6 = A..G, bit7 = DP.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Glyphs (logical, before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. DP (bit7) comes only from `dp`.
- Counters: `pre` counts 0..CLK_DIV-1. `dig` counts 0..N_DIGITS-1 and advances when `pre` wraps. `dig` wraps N_DIGITS-1→0, which is the frame boundary.
- Registers: staging (value/dp/blank_lz plus `pending`) and shadow. Display always reads shadow.
- load=1: staging ← inputs, pending ← 1. Repeated loads within a frame: last one wins.
- At a frame boundary with pending=1: shadow ← staging, pending ← 0.
- load coincident with a frame boundary: inputs go straight to shadow and pending ← 0.
- Slot output:
  - pre < BLANK_CYC: all digits off, seg off.
  - Otherwise: an = one-hot(dig), seg = glyph(shadow nibble dig) | dp bit.
- Leading-zero blank applies to digit i when blank_lz=1, i ≠ 0, and shadow nibbles i..N_DIGITS-1 are all zero.
  - A blanked digit drives segments A–G off, but still shows DP if its dp bit is set.
  - Digit 0 is never blanked.
- N_DIGITS=1: every slot wrap is a frame boundary.

## Timing
- Reset values:
  - pre=0, dig=0, staging=0, shadow=0, pending=0.
  - an and seg_out at logical 0: all off, pin level per ACTIVE_LOW.
  - frame_done=0.
- Reset applied mid-scan: everything above is restored at the next edge. No partial frame is resumed.
- an, seg_out and frame_done are registered: at each edge they take the value computed from pre/dig/shadow before that edge (one-cycle latency).
- Edge numbering: edge 1 is the first rising edge with rst=0.
  - Edge 1 outputs slot pre=0 of digit 0.
  - Digit d is lit for CLK_DIV-BLANK_CYC cycles per frame.
  - Frame period is N_DIGITS*CLK_DIV cycles.
- frame_done is high for the single cycle after the edge at which dig wraps to 0; shadow updates on that same edge.
- Load-to-display latency is between 1 and N_DIGITS*CLK_DIV+1 cycles; the display never shows a mix of old and new values within one frame.

## Structure
- Package `seg7_pkg`:
  - segment bit-position constants (SEG_A..SEG_G, SEG_DP);
  - the 16-entry glyph constant array;
  - a `glyph(nibble)` function.
- Sub-module `seg7_glyph`: combinational nibble+dp+blank → 8-bit segments, instantiated once (after the digit mux), not per digit.
- Polarity inversion is applied only at the output registers.

## Test plan
Bench parameters: N_DIGITS=4, CLK_DIV=4, BLANK_CYC=1, ACTIVE_LOW=0.
- Reset then idle:
  - an=0000 and seg_out=00 during reset;
  - after release, digit 0 lit edges 2–4 with seg 3F, an=0001;
  - edge 5 blank;
  - digit 1 lit edges 6–8, an=0010;
  - frame_done pulses after edge 16.
- Load value=16'h12AF, dp=4'b0100, blank_lz=0 mid-frame:
  - old zeros persist until the frame boundary;
  - next frame shows 71, 77, DB (5B|80), 06 on digits 0..3.
- Load value=16'h0050, blank_lz=1: digits 3 and 2 show 00, digit 1 shows 6D, digit 0 shows 3F.
  - value=16'h0000: only digit 0 shows 3F.
  - adding dp=4'b1000: digit 3 shows 80.
- Two loads in one frame (16'h1111 then 16'h2222), plus a load exactly on the boundary edge: only 2222 and the boundary value ever appear; pending clears.
- Reset asserted during digit 2 slot: at the next edge all outputs off and shadow=0; after release, scan restarts at digit 0.
- ACTIVE_LOW=1 rerun of the first scenario: all pin levels inverted, same timing.
